// File: rtl/decoder_n_seq_if.sv
// Select handshake between a select source (master) and decoder_n_seq (slave).
// A select value transfers on any rising clk edge where sel_valid && sel_ready are both 1;
// sel_valid may rise independently of sel_ready, and sel_in must stay stable while sel_valid waits.
interface decoder_n_seq_if #(
  parameter int SEL_W = 2
);
  logic [SEL_W-1:0] sel_in;
  logic             sel_valid;
  logic             sel_ready;

  modport master (output sel_in, output sel_valid, input sel_ready);
  modport slave  (input sel_in, input sel_valid, output sel_ready);
endinterface

// File: rtl/decoder_n_seq.sv
// Registered binary-to-one-hot decoder with a select sequencer: direct decode of a
// handshaked index, or automatic continuous / single-sweep scanning with a per-line dwell.
module decoder_n_seq #(
  parameter int SEL_W       = 2,
  parameter int DWELL       = 4,
  parameter bit ACTIVE_HIGH = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [1:0]            mode,
  decoder_n_seq_if.slave        sel_bus,
  output logic [(2**SEL_W)-1:0] y,
  output logic [SEL_W-1:0]      cur_sel,
  output logic                  wrap,
  output logic                  done,
  output logic                  busy,
  output logic [2:0]            fsm_state
);
  localparam int OUT_W = 2 ** SEL_W;
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] SEL_MAX  = '1;
  localparam logic [OUT_W-1:0] Y_IDLE   = {OUT_W{~ACTIVE_HIGH}};

  // OFF encodes as 0 so the debug state reads 0 out of reset
  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_DIRECT  = 3'd1,
    S_SCAN    = 3'd2,
    S_OS_RUN  = 3'd3,
    S_OS_DONE = 3'd4
  } state_t;

  state_t           state;
  state_t           nxt_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] nxt_cnt;
  logic [SEL_W-1:0] nxt_sel;
  logic [OUT_W-1:0] nxt_y;
  logic             frozen;
  logic             entry;
  logic             load;
  logic             advance;
  logic             cnt_last;
  logic             nxt_wrap;

  function automatic logic [OUT_W-1:0] line(input logic [SEL_W-1:0] s);
    logic [OUT_W-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return ACTIVE_HIGH ? v : ~v;
  endfunction

  always_comb begin
    nxt_state = state;
    case (mode)
      2'b00:   nxt_state = S_OFF;
      2'b01:   nxt_state = S_DIRECT;
      2'b10:   nxt_state = S_SCAN;
      default: nxt_state = (state == S_OS_RUN || state == S_OS_DONE) ? state : S_OS_RUN;
    endcase
    cnt_last = (cnt == LAST_CNT);
    if (state == S_OS_RUN && nxt_state == S_OS_RUN && !frozen && cnt_last && cur_sel == SEL_MAX)
      nxt_state = S_OS_DONE;

    entry   = (nxt_state == S_SCAN && state != S_SCAN) ||
              (nxt_state == S_OS_RUN && state != S_OS_RUN);
    load    = (state == S_DIRECT) && sel_bus.sel_valid && sel_bus.sel_ready;
    // the first enabled edge after a freeze only restores y, so the dwell resumes where it stopped
    advance = !frozen && !entry && (nxt_state == S_SCAN || nxt_state == S_OS_RUN);

    nxt_cnt  = cnt;
    nxt_sel  = cur_sel;
    nxt_wrap = 1'b0;
    if (entry) begin
      nxt_cnt = '0;
      nxt_sel = '0;
    end else if (load) begin
      nxt_sel = sel_bus.sel_in;
    end else if (advance) begin
      if (cnt_last) begin
        nxt_cnt  = '0;
        nxt_sel  = cur_sel + SEL_W'(1);
        nxt_wrap = (nxt_state == S_SCAN) && (cur_sel == SEL_MAX);
      end else begin
        nxt_cnt = cnt + CNT_W'(1);
      end
    end

    case (nxt_state)
      S_DIRECT, S_SCAN, S_OS_RUN: nxt_y = line(nxt_sel);
      default:                    nxt_y = Y_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_OFF;
      cnt               <= '0;
      cur_sel           <= '0;
      y                 <= Y_IDLE;
      wrap              <= 1'b0;
      done              <= 1'b0;
      busy              <= 1'b0;
      sel_bus.sel_ready <= 1'b1;
      frozen            <= 1'b0;
    end else if (!en) begin
      y                 <= Y_IDLE;
      wrap              <= 1'b0;
      done              <= 1'b0;
      sel_bus.sel_ready <= 1'b0;
      frozen            <= 1'b1;
    end else begin
      state             <= nxt_state;
      cnt               <= nxt_cnt;
      cur_sel           <= nxt_sel;
      y                 <= nxt_y;
      wrap              <= nxt_wrap;
      done              <= (state == S_OS_RUN) && (nxt_state == S_OS_DONE);
      busy              <= (nxt_state == S_SCAN) || (nxt_state == S_OS_RUN);
      sel_bus.sel_ready <= (nxt_state == S_OFF) || (nxt_state == S_DIRECT);
      frozen            <= 1'b0;
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_decoder_n_seq.sv
// Bench for decoder_n_seq: four configurations driven in lockstep, compared each cycle
// against a sweep-position model plus directed checks of reset, direct, scan, oneshot and freeze.
module tb_decoder_n_seq;
  localparam int M_OFF = 0, M_DIRECT = 1, M_SCAN = 2, M_OSRUN = 3, M_OSDONE = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       sel_valid = 1'b0;
  logic [2:0] sel_raw = 3'd0;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // configs: a = 2b/dwell4/high, b = 3b/dwell1/high, c = 1b/dwell1/high, d = 2b/dwell4/low
  int p_sw[4] = '{2, 3, 1, 2};
  int p_dw[4] = '{4, 1, 1, 4};
  bit p_ah[4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  decoder_n_seq_if #(.SEL_W(2)) bus_a ();
  decoder_n_seq_if #(.SEL_W(3)) bus_b ();
  decoder_n_seq_if #(.SEL_W(1)) bus_c ();
  decoder_n_seq_if #(.SEL_W(2)) bus_d ();

  assign bus_a.sel_in = sel_raw[1:0];
  assign bus_b.sel_in = sel_raw;
  assign bus_c.sel_in = sel_raw[0:0];
  assign bus_d.sel_in = sel_raw[1:0];
  assign bus_a.sel_valid = sel_valid;
  assign bus_b.sel_valid = sel_valid;
  assign bus_c.sel_valid = sel_valid;
  assign bus_d.sel_valid = sel_valid;

  logic [3:0] y_a, y_d;
  logic [7:0] y_b;
  logic [1:0] y_c;
  logic [1:0] cs_a, cs_d;
  logic [2:0] cs_b;
  logic [0:0] cs_c;
  logic [3:0] wrap_v, done_v, busy_v;
  logic [2:0] st_a, st_b, st_c, st_d;

  decoder_n_seq #(.SEL_W(2), .DWELL(4), .ACTIVE_HIGH(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_bus(bus_a), .y(y_a), .cur_sel(cs_a),
    .wrap(wrap_v[0]), .done(done_v[0]), .busy(busy_v[0]), .fsm_state(st_a));
  decoder_n_seq #(.SEL_W(3), .DWELL(1), .ACTIVE_HIGH(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_bus(bus_b), .y(y_b), .cur_sel(cs_b),
    .wrap(wrap_v[1]), .done(done_v[1]), .busy(busy_v[1]), .fsm_state(st_b));
  decoder_n_seq #(.SEL_W(1), .DWELL(1), .ACTIVE_HIGH(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_bus(bus_c), .y(y_c), .cur_sel(cs_c),
    .wrap(wrap_v[2]), .done(done_v[2]), .busy(busy_v[2]), .fsm_state(st_c));
  decoder_n_seq #(.SEL_W(2), .DWELL(4), .ACTIVE_HIGH(1'b0)) dut_d (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_bus(bus_d), .y(y_d), .cur_sel(cs_d),
    .wrap(wrap_v[3]), .done(done_v[3]), .busy(busy_v[3]), .fsm_state(st_d));

  // model: a sweep is a count of dwell-cycles since entry; the line shown is phase/dwell mod lines
  int m_st[4];
  int m_sel[4];
  int m_phase[4];
  bit m_yon[4], m_wrap[4], m_done[4], m_busy[4], m_ready[4], m_frozen[4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 4; d++) begin
      m_st[d] = M_OFF; m_sel[d] = 0; m_phase[d] = 0;
      m_yon[d] = 1'b0; m_wrap[d] = 1'b0; m_done[d] = 1'b0;
      m_busy[d] = 1'b0; m_ready[d] = 1'b1; m_frozen[d] = 1'b0;
    end
  endfunction

  function automatic void model_edge(input int d);
    int ow = 1 << p_sw[d];
    int span = ow * p_dw[d];
    int nst;
    bit load, entering;
    if (!en) begin
      m_yon[d] = 1'b0; m_wrap[d] = 1'b0; m_done[d] = 1'b0; m_ready[d] = 1'b0; m_frozen[d] = 1'b1;
      return;
    end
    case (mode)
      2'd0:    nst = M_OFF;
      2'd1:    nst = M_DIRECT;
      2'd2:    nst = M_SCAN;
      default: nst = (m_st[d] == M_OSRUN || m_st[d] == M_OSDONE) ? m_st[d] : M_OSRUN;
    endcase
    load = (m_st[d] == M_DIRECT) && sel_valid && m_ready[d];
    entering = (nst == M_SCAN && m_st[d] != M_SCAN) || (nst == M_OSRUN && m_st[d] != M_OSRUN);
    m_wrap[d] = 1'b0;
    m_done[d] = 1'b0;
    if (entering) begin
      m_phase[d] = 0;
      m_sel[d] = 0;
    end else if (load) begin
      m_sel[d] = int'(sel_raw) % ow;
    end else if ((nst == M_SCAN || nst == M_OSRUN) && !m_frozen[d]) begin
      m_phase[d]++;
      if (nst == M_OSRUN && m_phase[d] == span) begin
        nst = M_OSDONE;
        m_done[d] = 1'b1;
      end else begin
        m_sel[d] = (m_phase[d] / p_dw[d]) % ow;
        m_wrap[d] = (nst == M_SCAN) && (m_phase[d] % span == 0);
      end
    end
    m_st[d] = nst;
    m_yon[d] = (nst == M_DIRECT || nst == M_SCAN || nst == M_OSRUN);
    m_busy[d] = (nst == M_SCAN || nst == M_OSRUN);
    m_ready[d] = (nst == M_OFF || nst == M_DIRECT);
    m_frozen[d] = 1'b0;
  endfunction

  function automatic logic [31:0] exp_y(input int d);
    int ow = 1 << p_sw[d];
    logic [31:0] v;
    v = m_yon[d] ? (32'd1 << m_sel[d]) : 32'd0;
    if (!p_ah[d]) v = ~v & ((32'd1 << ow) - 32'd1);
    return v;
  endfunction

  task automatic check_dut(input int d, input logic [31:0] gy, input logic [31:0] gs,
                           input logic gw, input logic gd, input logic gb, input logic gr);
    check($sformatf("d%0d_y", d), gy, exp_y(d));
    check($sformatf("d%0d_cur_sel", d), gs, 32'(m_sel[d]));
    check($sformatf("d%0d_wrap", d), 32'(gw), 32'(m_wrap[d]));
    check($sformatf("d%0d_done", d), 32'(gd), 32'(m_done[d]));
    check($sformatf("d%0d_busy", d), 32'(gb), 32'(m_busy[d]));
    check($sformatf("d%0d_sel_ready", d), 32'(gr), 32'(m_ready[d]));
  endtask

  task automatic compare_all();
    check_dut(0, 32'(y_a), 32'(cs_a), wrap_v[0], done_v[0], busy_v[0], bus_a.sel_ready);
    check_dut(1, 32'(y_b), 32'(cs_b), wrap_v[1], done_v[1], busy_v[1], bus_b.sel_ready);
    check_dut(2, 32'(y_c), 32'(cs_c), wrap_v[2], done_v[2], busy_v[2], bus_c.sel_ready);
    check_dut(3, 32'(y_d), 32'(cs_d), wrap_v[3], done_v[3], busy_v[3], bus_d.sel_ready);
  endtask

  // drive at the falling edge, let the DUTs and the model take the rising edge, compare at the next fall
  task automatic tick(input bit e, input logic [1:0] m, input bit v, input logic [2:0] s);
    en = e; mode = m; sel_valid = v; sel_raw = s;
    @(posedge clk);
    for (int d = 0; d < 4; d++) model_edge(d);
    @(negedge clk);
    compare_all();
  endtask

  logic [1:0] rnd_mode;

  initial begin
    model_reset();
    @(negedge clk);
    compare_all();
    check("rst_state_a", 32'(st_a), 32'd0);
    check("rst_state_d", 32'(st_d), 32'd0);
    rst_n = 1'b1;

    // direct decode
    tick(1'b1, 2'b01, 1'b0, 3'd0);
    tick(1'b1, 2'b01, 1'b1, 3'd2);
    check("direct_y2", 32'(y_a), 32'h4);
    check("direct_sel2", 32'(cs_a), 32'd2);
    tick(1'b1, 2'b01, 1'b1, 3'd3);
    check("direct_y3", 32'(y_a), 32'h8);
    tick(1'b1, 2'b01, 1'b0, 3'd1);
    tick(1'b1, 2'b01, 1'b0, 3'd0);
    check("direct_hold_y", 32'(y_a), 32'h8);
    check("direct_hold_sel", 32'(cs_a), 32'd3);

    // continuous scan, entered with a competing handshake
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 2'b10, 1'b1, 3'($urandom_range(0, 7)));
      check("scan_y_a", 32'(y_a), 32'd1 << ((i / 4) % 4));
      check("scan_wrap_a", 32'(wrap_v[0]), 32'(i == 16));
      check("scan_ready_a", 32'(bus_a.sel_ready), 32'd0);
      check("scan_y_d", 32'(y_d), ~(32'd1 << ((i / 4) % 4)) & 32'hF);
      check("scan_y_c", 32'(y_c), 32'd1 << (i % 2));
      check("scan_wrap_c", 32'(wrap_v[2]), 32'(i > 0 && i % 2 == 0));
    end

    // single sweep on the 3-bit, dwell-1 instance
    tick(1'b1, 2'b00, 1'b0, 3'd0);
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, 2'b11, 1'b0, 3'd0);
      check("os_y_b", 32'(y_b), (i < 8) ? (32'd1 << i) : 32'd0);
      check("os_done_b", 32'(done_v[1]), 32'(i == 8));
      check("os_busy_b", 32'(busy_v[1]), 32'(i < 8));
    end
    check("os_sel_end_b", 32'(cs_b), 32'd7);
    tick(1'b1, 2'b00, 1'b0, 3'd0);
    tick(1'b1, 2'b11, 1'b0, 3'd0);
    check("os_rearm_b", 32'(y_b), 32'h01);

    // enable freeze at count 2 of index 1
    tick(1'b1, 2'b00, 1'b0, 3'd0);
    for (int i = 0; i < 7; i++) tick(1'b1, 2'b10, 1'b0, 3'd0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 2'b10, 1'b0, 3'd0);
      check("frz_y_a", 32'(y_a), 32'h0);
      check("frz_y_d", 32'(y_d), 32'hF);
    end
    tick(1'b1, 2'b10, 1'b0, 3'd0);
    check("frz_resume1", 32'(y_a), 32'h2);
    tick(1'b1, 2'b10, 1'b0, 3'd0);
    check("frz_resume2", 32'(y_a), 32'h2);
    tick(1'b1, 2'b10, 1'b0, 3'd0);
    check("frz_next", 32'(y_a), 32'h4);

    // asynchronous reset in the middle of a cycle while scanning
    tick(1'b1, 2'b10, 1'b0, 3'd0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_y_a", 32'(y_a), 32'h0);
    check("arst_y_d", 32'(y_d), 32'hF);
    check("arst_sel_a", 32'(cs_a), 32'd0);
    check("arst_ready_a", 32'(bus_a.sel_ready), 32'd1);
    check("arst_busy_a", 32'(busy_v[0]), 32'd0);
    check("arst_state_b", 32'(st_b), 32'd0);
    check("arst_state_c", 32'(st_c), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    compare_all();

    // randomized run with sticky modes, enable drops and random handshakes
    rnd_mode = 2'b01;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) rnd_mode = 2'($urandom_range(0, 3));
      tick(($urandom_range(0, 9) != 0), rnd_mode, 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
